// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Optional feature macro: KEY_LONG_PRESS_EN (long-press detector).
package key_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        KEY_UP      = 2'd0,
        KEY_DN_WAIT = 2'd1,
        KEY_DN      = 2'd2,
        KEY_UP_WAIT = 2'd3
    } key_state_e;

    // 20 ms and 1 s at 12 MHz.
    localparam int KEY_DEBOUNCE_DEFAULT = 240000;
    localparam int KEY_LONG_DEFAULT     = 12000000;

    function automatic int key_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, polarity normalisation, debounce FSM
// with a saturating counter, and registered level/press/release/long outputs.
// Optional feature macro: KEY_LONG_PRESS_EN (adds the held-time counter in DN).
//
// Handshake: none. Outputs are free-running; press/release/long are
// single-cycle pulses that the consumer samples on any clock edge.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
`ifdef KEY_LONG_PRESS_EN
    parameter int LONG_CYCLES     = KEY_LONG_DEFAULT,
`endif
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_raw,
    output logic       o_key_level,
    output logic       o_key_press,
    output logic       o_key_release,
    output logic       o_key_long,
    output logic [1:0] o_dbg_state
);

`ifdef KEY_LONG_PRESS_EN
    localparam int CNT_TOP = key_max(DEBOUNCE_CYCLES, LONG_CYCLES);
`else
    localparam int CNT_TOP = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
`endif

    // Raw level of an idle (released) key.
    localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

    logic             sync_1;
    logic             sync_2;
    logic             pressed;
    key_state_e       state;
    key_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    // Bring the asynchronous key into i_clk; reset parks it at "released".
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_1 <= RAW_RELEASED;
            sync_2 <= RAW_RELEASED;
        end else begin
            sync_1 <= i_key_raw;
            sync_2 <= sync_1;
        end
    end

    assign pressed = sync_2 ^ RAW_RELEASED;

    // Next-state and counter logic of the debounce FSM.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            KEY_UP: begin
                if (pressed) begin
                    state_nxt = KEY_DN_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            KEY_DN_WAIT: begin
                if (!pressed) begin
                    state_nxt = KEY_UP;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == DB_LAST) begin
                    state_nxt = KEY_DN;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            KEY_DN: begin
                if (!pressed) begin
                    state_nxt = KEY_UP_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
`ifdef KEY_LONG_PRESS_EN
                else if (cnt != LONG_SAT) begin
                    // Held time; stops at LONG_CYCLES so the long pulse fires once.
                    cnt_nxt = cnt + CNT_ONE;
                end
`endif
            end
            KEY_UP_WAIT: begin
                if (pressed) begin
                    // Bounce back to pressed: held time restarts from zero.
                    state_nxt = KEY_DN;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == DB_LAST) begin
                    state_nxt = KEY_UP;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = KEY_UP;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= KEY_UP;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs. level_q holds the previous cycle's level, so DN with
    // level_q low means DN was just entered from DN_WAIT, and UP with level_q
    // high means UP was just entered from UP_WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= (state == KEY_DN) || (state == KEY_UP_WAIT);
            press_q   <= (state == KEY_DN) && !level_q;
            release_q <= (state == KEY_UP) && level_q;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    logic long_q;

    // One pulse on the edge after the held count hits LONG_CYCLES-1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            long_q <= 1'b0;
        end else begin
            long_q <= (state == KEY_DN) && (cnt == LONG_LAST);
        end
    end

    assign o_key_long = long_q;
`else
    assign o_key_long = 1'b0;
`endif

    assign o_key_level   = level_q;
    assign o_key_press   = press_q;
    assign o_key_release = release_q;
    assign o_dbg_state   = state;

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end for the recorder/player control FSM: N_KEYS
// independent debounced channels. o_dbg_state packs each channel's FSM state
// (2 bits per key, key k at [2k+1:2k]).
// Optional feature macro: KEY_LONG_PRESS_EN (long-press pulse on o_key_long).
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = KEY_LONG_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_KEYS-1:0]   i_key_raw,
    output logic [N_KEYS-1:0]   o_key_level,
    output logic [N_KEYS-1:0]   o_key_press,
    output logic [N_KEYS-1:0]   o_key_release,
    output logic [N_KEYS-1:0]   o_key_long,
    output logic [2*N_KEYS-1:0] o_dbg_state
);

    // Elaboration-time parameter sanity.
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
        $error("key_conditioner: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    // One independent conditioner per key.
    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef KEY_LONG_PRESS_EN
            .LONG_CYCLES     (LONG_CYCLES),
`endif
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_key_raw     (i_key_raw[k]),
            .o_key_level   (o_key_level[k]),
            .o_key_press   (o_key_press[k]),
            .o_key_release (o_key_release[k]),
            .o_key_long    (o_key_long[k]),
            .o_dbg_state   (o_dbg_state[2*k +: 2])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, active-low).
// Works with or without KEY_LONG_PRESS_EN defined.
// Reference model: a key's accepted level flips once DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with it; outputs lag by a cycle.
module tb_key_conditioner;
    import key_pkg::*;

    localparam int N = 3;
    localparam int D = 8;
    localparam int L = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   raw = '1;
    logic [N-1:0]   o_key_level;
    logic [N-1:0]   o_key_press;
    logic [N-1:0]   o_key_release;
    logic [N-1:0]   o_key_long;
    logic [2*N-1:0] o_dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Event bookkeeping (count and last cycle seen) per key.
    int n_press[N];
    int n_rel[N];
    int n_long[N];
    int t_press[N];
    int t_rel[N];
    int t_long[N];

    // Reference model state.
    logic [N-1:0] h1 = '0;
    logic [N-1:0] h2 = '0;
    int           acc[N];
    int           run[N];
    int           hold[N];
    logic [N-1:0] pend_level = '0, pend_press = '0, pend_rel = '0, pend_long = '0;
    logic [N-1:0] exp_level = '0, exp_press = '0, exp_rel = '0, exp_long = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    key_conditioner #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .ACTIVE_LOW      (1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_raw     (raw),
        .o_key_level   (o_key_level),
        .o_key_press   (o_key_press),
        .o_key_release (o_key_release),
        .o_key_long    (o_key_long),
        .o_dbg_state   (o_dbg_state)
    );

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: compare every cycle, then advance the model for the next edge.
    initial begin
        for (int k = 0; k < N; k++) begin
            acc[k] = 0; run[k] = 0; hold[k] = 0;
        end
        forever begin
            @(negedge clk);
            check_eq("level",   o_key_level,   exp_level);
            check_eq("press",   o_key_press,   exp_press);
            check_eq("release", o_key_release, exp_rel);
            check_eq("long",    o_key_long,    exp_long);
            for (int k = 0; k < N; k++) begin
                if (o_key_press[k])   begin n_press[k]++; t_press[k] = cyc; end
                if (o_key_release[k]) begin n_rel[k]++;   t_rel[k]   = cyc; end
                if (o_key_long[k])    begin n_long[k]++;  t_long[k]  = cyc; end
            end
            if (rst) begin
                exp_level = '0; exp_press = '0; exp_rel = '0; exp_long = '0;
                pend_level = '0; pend_press = '0; pend_rel = '0; pend_long = '0;
                h1 = '0; h2 = '0;
                for (int k = 0; k < N; k++) begin
                    acc[k] = 0; run[k] = 0; hold[k] = 0;
                end
            end else begin
                exp_level = pend_level; exp_press = pend_press;
                exp_rel   = pend_rel;   exp_long  = pend_long;
                for (int k = 0; k < N; k++) begin
                    int s;
                    bit flip;
                    s = int'(h2[k]);
                    h2[k] = h1[k];
                    h1[k] = ~raw[k];
                    flip = 1'b0;
                    pend_press[k] = 1'b0;
                    pend_rel[k]   = 1'b0;
                    pend_long[k]  = 1'b0;
                    if (s != acc[k]) begin
                        run[k]++;
                        if (run[k] == D) begin
                            acc[k] = s;
                            run[k] = 0;
                            flip = 1'b1;
                            hold[k] = s;
                            if (s == 1) pend_press[k] = 1'b1;
                            else        pend_rel[k]   = 1'b1;
                        end
                    end else begin
                        run[k] = 0;
                    end
                    if (acc[k] == 1 && !flip) begin
                        if (s == 1) begin
                            if (hold[k] <= L) hold[k]++;
                        end else begin
                            hold[k] = 0;
                        end
                    end
`ifdef KEY_LONG_PRESS_EN
                    if (acc[k] == 1 && s == 1 && hold[k] == L) pend_long[k] = 1'b1;
`endif
                    pend_level[k] = (acc[k] == 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input bit p);
        raw[k] = ~p;
    endtask

    task automatic clr_counts();
        for (int k = 0; k < N; k++) begin
            n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0;
            t_press[k] = -1; t_rel[k] = -1; t_long[k] = -1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, c1, r;
        int tmr[N];
        logic [2*N-1:0] up_all;

        up_all = {KEY_UP, KEY_UP, KEY_UP};
        clr_counts();
        rst = 1'b1;
        raw = '1;
        tick(3);
        @(negedge clk);
        check_eq("rst_dbg_state", o_dbg_state, up_all);
        check_eq("rst_outputs", {o_key_level, o_key_press, o_key_release, o_key_long}, 0);
        tick(1);
        rst = 1'b0;
        tick(10);

        // Clean press on key0 held 50 cycles, then release.
        clr_counts();
        c0 = cyc;
        set_key(0, 1);
        tick(50);
        c1 = cyc;
        set_key(0, 0);
        tick(D + 6);
        check_eq("clean_press_n",   n_press[0], 1);
        check_eq("clean_press_lat", t_press[0] - c0, D + 3);
        check_eq("clean_rel_n",     n_rel[0], 1);
        check_eq("clean_rel_lat",   t_rel[0] - c1, D + 3);
`ifdef KEY_LONG_PRESS_EN
        check_eq("long_n",   n_long[0], 1);
        check_eq("long_lat", t_long[0] - c0, D + L + 2);
`else
        check_eq("long_n", n_long[0], 0);
`endif

        // Bouncing key1 (3,2,5,2 cycle segments) then settles pressed.
        clr_counts();
        set_key(1, 1); tick(3);
        set_key(1, 0); tick(2);
        set_key(1, 1); tick(5);
        set_key(1, 0); tick(2);
        c0 = cyc;
        set_key(1, 1);
        tick(20);
        check_eq("bounce_press_n",   n_press[1], 1);
        check_eq("bounce_press_lat", t_press[1] - c0, D + 3);
        set_key(1, 0);
        tick(D + 6);
        check_eq("bounce_rel_n", n_rel[1], 1);

        // Glitch on key2 one cycle short of the debounce window, then exactly on it.
        clr_counts();
        set_key(2, 1); tick(D - 1);
        set_key(2, 0); tick(D + 6);
        check_eq("glitch_press_n", n_press[2], 0);
        check_eq("glitch_rel_n",   n_rel[2], 0);
        set_key(2, 1); tick(D);
        set_key(2, 0); tick(D + 6);
        check_eq("edge_press_n", n_press[2], 1);
        check_eq("edge_rel_n",   n_rel[2], 1);

        // Keys 0 and 2 pressed together.
        clr_counts();
        c0 = cyc;
        set_key(0, 1);
        set_key(2, 1);
        tick(D + 6);
        check_eq("sim_press_align", t_press[0], t_press[2]);
        check_eq("sim_press_lat",   t_press[2] - c0, D + 3);
        set_key(0, 0);
        set_key(2, 0);
        tick(D + 6);

        // Reset while key1 is mid-debounce; key stays held through reset.
        clr_counts();
        set_key(1, 1);
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        r = cyc;
        tick(D + 6);
        check_eq("rst_press_n",   n_press[1], 1);
        check_eq("rst_press_lat", t_press[1] - r, D + 3);
        set_key(1, 0);
        tick(D + 6);

        // Random segments of mixed short (glitch) and long (hold) lengths.
        for (int k = 0; k < N; k++) tmr[k] = $urandom_range(1, 20);
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (tmr[k] == 0) begin
                    raw[k] = ~raw[k];
                    if ($urandom_range(0, 2) == 0) tmr[k] = $urandom_range(1, D + 1);
                    else                           tmr[k] = $urandom_range(D - 1, L + 12);
                end else begin
                    tmr[k]--;
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0;
        raw = '1;
        tick(D + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
